// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states, bus widths,
// and the address legality check used at request acceptance.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  // A request is illegal if it is not word aligned or falls outside the array.
  function automatic logic addrBad(input logic [WORD_W-1:0] addr, input int depthLog2);
    return (addr[1:0] != 2'b00) || ((addr >> (depthLog2 + 2)) != '0);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Byte-enabled synchronous RAM: one registered read port and one write port, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  readEn,
  input  logic [DEPTH_LOG2-1:0] readIdx,
  output logic [WORD_W-1:0]     readData,
  input  logic                  writeEn,
  input  logic [BE_W-1:0]       writeBe,
  input  logic [DEPTH_LOG2-1:0] writeIdx,
  input  logic [WORD_W-1:0]     writeData
);
  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (readEn) readData <= mem[readIdx];
  end

  for (genvar b = 0; b < BE_W; b++) begin : g_byte
    always_ff @(posedge clk) begin
      if (writeEn && writeBe[b]) mem[writeIdx][8*b +: 8] <= writeData[8*b +: 8];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core's load/store port with configurable wait states.
// Define DMEM_MAILBOX_EN to decode the simulation pass/fail mailbox.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2   = 6,
  parameter int          WAIT_STATES  = 1,
  parameter logic [31:0] MAILBOX_ADDR = 32'h54,
  parameter logic [31:0] PASS_CODE    = 32'h7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_we,
  input  logic [BE_W-1:0]   mem_be,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              stall,
  output logic              test_done,
  output logic              test_pass
);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  stateT             state;
  logic [3:0]        waitCnt;
  logic              reqWe;
  logic              reqErr;
  logic [BE_W-1:0]   reqBe;
  logic [WORD_W-1:0] reqAddr;
  logic [WORD_W-1:0] reqWdata;
  logic [WORD_W-1:0] arrQ;

  logic                  errLive;
  logic                  respErr;
  logic                  enterResp;
  logic [DEPTH_LOG2-1:0] readIdx;
  logic                  writeEn;

  assign errLive = addrBad(mem_addr, DEPTH_LOG2);

  // With zero wait states the read launches on the accepting edge, so it must
  // use the live request rather than the not-yet-latched copy.
  always_comb begin
    enterResp = 1'b0;
    respErr   = reqErr;
    readIdx   = reqAddr[DEPTH_LOG2+1:2];
    if (state == IDLE) begin
      enterResp = mem_en && (WAIT_STATES == 0);
      respErr   = errLive;
      readIdx   = mem_addr[DEPTH_LOG2+1:2];
    end else if (state == WAIT) begin
      enterResp = (waitCnt == 4'd0);
    end
  end

  assign writeEn = (state == RESP) && reqWe && !reqErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      reqWe     <= 1'b0;
      reqErr    <= 1'b0;
      reqBe     <= '0;
      reqAddr   <= '0;
      reqWdata  <= '0;
    end else begin
      case (state)
        IDLE: if (mem_en) begin
          reqWe    <= mem_we;
          reqErr   <= errLive;
          reqBe    <= mem_be;
          reqAddr  <= mem_addr;
          reqWdata <= mem_wdata;
          if (WAIT_STATES == 0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_err   <= errLive;
          end else begin
            state   <= WAIT;
            waitCnt <= WAIT_INIT;
          end
        end
        WAIT: if (waitCnt == 4'd0) begin
          state     <= RESP;
          mem_ready <= 1'b1;
          mem_err   <= reqErr;
        end else begin
          waitCnt <= waitCnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) uArray (
    .clk      (clk),
    .readEn   (enterResp && !respErr),
    .readIdx  (readIdx),
    .readData (arrQ),
    .writeEn  (writeEn),
    .writeBe  (reqBe),
    .writeIdx (reqAddr[DEPTH_LOG2+1:2]),
    .writeData(reqWdata)
  );

  // Read data is only presented during a clean completion; otherwise it is zero.
  assign mem_rdata = (mem_ready && !mem_err) ? arrQ : '0;
  assign stall     = mem_en && !mem_ready;

`ifdef DMEM_MAILBOX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
    end else if (state == RESP && reqWe && reqAddr == MAILBOX_ADDR &&
                 reqBe == 4'hF && !test_done) begin
      test_done <= 1'b1;
      test_pass <= (reqWdata == PASS_CODE);
    end
  end
`else
  logic [95:0] unusedMailbox;
  assign unusedMailbox = {MAILBOX_ADDR, PASS_CODE, reqAddr};
  assign test_done     = 1'b0;
  assign test_pass     = 1'b0;
`endif
endmodule
